// File: rtl/sr_latch_arbiter.sv
// ---------------------------------------------------------------------------
// sr_latch_arbiter
//
// Purpose:
//   Shares one external NOR-based SR latch between two clocked requesters.
//   Requests are arbitrated round-robin. The winner's operation drives a
//   timed S (set) or R (reset) pulse, followed by a settle window with
//   S=R=0, then a single check cycle that pulses the owner's done flag.
//   S and R are registered and come from a single op bit, so they are
//   never high together.
//
// Parameters:
//   PULSE_CYC  - cycles S or R is held high per operation (>= 1)
//   SETTLE_CYC - cycles with S=R=0 before completion (>= 1)
//   CNT_W      - cycle counter width; must hold max(PULSE_CYC, SETTLE_CYC)
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active high
//   req_a / op_a   requester A request (held until done_a) and op (1=set)
//   req_b / op_b   requester B request and op
//   done_a/done_b  one-cycle completion pulses, never concurrent
//   S / R          drives to the latch inputs
//   Q / Qn         latch readback
//   busy           high whenever the controller is not idle
//   err            sticky readback-mismatch flag
//
// Configuration:
//   SR_READBACK_CHECK_EN - when defined, Q/Qn are compared with the expected
//   result during the check cycle and a mismatch (including Q=Qn=0) sets err
//   until reset. When undefined, Q/Qn are ignored and err is tied low.
// ---------------------------------------------------------------------------
module sr_latch_arbiter #(
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic op_a,
  input  logic req_b,
  input  logic op_b,
  output logic done_a,
  output logic done_b,
  output logic S,
  output logic R,
  input  logic Q,
  input  logic Qn,
  output logic busy,
  output logic err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic             OWN_A       = 1'b0;
  localparam logic             OWN_B       = 1'b1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             owner_q, owner_d;
  logic             rr_last_q, rr_last_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic [1:0]       done_q, done_d;
  logic             enter_check;
  logic             grant_valid;
  logic             grant_owner;

  // Round-robin pick: on contention the requester that did not win last.
  always_comb begin
    grant_valid = req_a | req_b;
    grant_owner = OWN_A;
    if (req_a && req_b) begin
      grant_owner = ~rr_last_q;
    end else if (req_b) begin
      grant_owner = OWN_B;
    end
  end

  // S/R default to 0 and are only raised while (entering or staying in)
  // DRIVE, so they can only change on state changes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    s_d         = 1'b0;
    r_d         = 1'b0;
    enter_check = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d   = grant_owner;
          op_d      = grant_owner ? op_b : op_a;
          rr_last_d = grant_owner;
          cnt_d     = '0;
          state_d   = ST_DRIVE;
          s_d       = op_d;
          r_d       = ~op_d;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          s_d   = op_q;
          r_d   = ~op_q;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d       = '0;
          state_d     = ST_CHECK;
          enter_check = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Done pulses are registered so they line up with the CHECK cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_done
    assign done_d[gi] = enter_check && (owner_q == 1'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      owner_q   <= OWN_A;
      rr_last_q <= OWN_B;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      s_q       <= s_d;
      r_q       <= r_d;
      done_q    <= done_d;
    end
  end

  assign S      = s_q;
  assign R      = r_q;
  assign done_a = done_q[0];
  assign done_b = done_q[1];
  assign busy   = (state_q != ST_IDLE);

`ifdef SR_READBACK_CHECK_EN
  logic err_q, err_d;
  logic readback_bad;

  // Q=Qn=0 always disagrees with one of the two expected levels, so the
  // forbidden readback is caught by the same comparison.
  always_comb begin
    readback_bad = (Q != op_q) || (Qn != ~op_q);
    err_d        = err_q;
    if ((state_q == ST_CHECK) && readback_bad) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_readback;
  assign unused_readback = Q ^ Qn;
  assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_arbiter.sv
module tb_sr_latch_arbiter;

  localparam int P0 = 2;
  localparam int C0 = 2;
  localparam int P1 = 3;
  localparam int C1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // DUT 0: default timing
  logic rst0, req_a0, op_a0, req_b0, op_b0;
  logic done_a0, done_b0, S0, R0, Q0, Qn0, busy0, err0;
  logic lq0 = 1'b0;
  logic stuck0 = 1'b0;

  // DUT 1: PULSE_CYC=3, SETTLE_CYC=1
  logic rst1, req_a1, op_a1, req_b1, op_b1;
  logic done_a1, done_b1, S1, R1, Q1, Qn1, busy1, err1;
  logic lq1 = 1'b0;

  sr_latch_arbiter dut0 (
    .clk(clk), .rst(rst0), .req_a(req_a0), .op_a(op_a0), .req_b(req_b0), .op_b(op_b0),
    .done_a(done_a0), .done_b(done_b0), .S(S0), .R(R0), .Q(Q0), .Qn(Qn0),
    .busy(busy0), .err(err0)
  );

  sr_latch_arbiter #(.PULSE_CYC(P1), .SETTLE_CYC(C1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1), .req_a(req_a1), .op_a(op_a1), .req_b(req_b1), .op_b(op_b1),
    .done_a(done_a1), .done_b(done_b1), .S(S1), .R(R1), .Q(Q1), .Qn(Qn1),
    .busy(busy1), .err(err1)
  );

  // Behavioural NOR latches; dut0's can be forced to read back Q=0.
  always @(S0, R0) begin
    if (S0 === 1'b1 && R0 !== 1'b1) lq0 = 1'b1;
    else if (R0 === 1'b1 && S0 !== 1'b1) lq0 = 1'b0;
  end
  assign Q0  = stuck0 ? 1'b0 : lq0;
  assign Qn0 = stuck0 ? 1'b1 : ~lq0;

  always @(S1, R1) begin
    if (S1 === 1'b1 && R1 !== 1'b1) lq1 = 1'b1;
    else if (R1 === 1'b1 && S1 !== 1'b1) lq1 = 1'b0;
  end
  assign Q1  = lq1;
  assign Qn1 = ~lq1;

  // S and R must never be high together on any cycle.
  always @(negedge clk) begin
    n_checks++;
    if (S0 === 1'b1 && R0 === 1'b1) begin
      n_fail++;
      $display("FAIL inv_SR_dut0 at %0t: S=%b R=%b, required not both 1", $time, S0, R0);
    end
    n_checks++;
    if (S1 === 1'b1 && R1 === 1'b1) begin
      n_fail++;
      $display("FAIL inv_SR_dut1 at %0t: S=%b R=%b, required not both 1", $time, S1, R1);
    end
  end

  task automatic test_reset();
    rst0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({S0, R0, busy0, done_a0, done_b0, err0} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: S,R,busy,done_a,done_b,err=%b required 000000",
               {S0, R0, busy0, done_a0, done_b0, err0});
    end
    rst0 = 1'b0;
  endtask

  task automatic test_single_set();
    bit exp_s, exp_busy, exp_da;
    req_a0 = 1'b1;
    op_a0  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      exp_s    = (k <= P0);
      exp_busy = (k <= P0 + C0 + 1);
      exp_da   = (k == P0 + C0 + 1);
      n_checks++;
      if (S0 !== exp_s) begin
        n_fail++;
        $display("FAIL single_S k=%0d: got %b required %b", k, S0, exp_s);
      end
      n_checks++;
      if (R0 !== 1'b0) begin
        n_fail++;
        $display("FAIL single_R k=%0d: got %b required 0", k, R0);
      end
      n_checks++;
      if (busy0 !== exp_busy) begin
        n_fail++;
        $display("FAIL single_busy k=%0d: got %b required %b", k, busy0, exp_busy);
      end
      n_checks++;
      if (done_a0 !== exp_da || done_b0 !== 1'b0) begin
        n_fail++;
        $display("FAIL single_done k=%0d: got a=%b b=%b required a=%b b=0", k, done_a0, done_b0, exp_da);
      end
      if (k == P0 + C0 + 1) begin
        req_a0 = 1'b0;
        $display("txn single: A set, done expected in cycle %0d counting the request cycle", k + 1);
      end
    end
    n_checks++;
    if (Q0 !== 1'b1 || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: got Q=%b err=%b required Q=1 err=0", Q0, err0);
    end
  endtask

  task automatic test_alternate();
    int period;
    int ph;
    bit own;
    bit exp_s, exp_r, exp_da, exp_db;
    int order[$];
    period = P0 + C0 + 2;
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0   = 1'b0;
    req_a0 = 1'b1; op_a0 = 1'b1;
    req_b0 = 1'b1; op_b0 = 1'b0;
    for (int k = 1; k <= 3 * period; k++) begin
      @(posedge clk);
      #1;
      ph     = ((k - 1) % period) + 1;
      own    = (((k - 1) / period) % 2) == 1;
      exp_s  = (ph <= P0) && !own;
      exp_r  = (ph <= P0) && own;
      exp_da = (ph == P0 + C0 + 1) && !own;
      exp_db = (ph == P0 + C0 + 1) && own;
      n_checks++;
      if (S0 !== exp_s || R0 !== exp_r) begin
        n_fail++;
        $display("FAIL alt_SR k=%0d: got S=%b R=%b required S=%b R=%b", k, S0, R0, exp_s, exp_r);
      end
      n_checks++;
      if (done_a0 !== exp_da || done_b0 !== exp_db) begin
        n_fail++;
        $display("FAIL alt_done k=%0d: got a=%b b=%b required a=%b b=%b", k, done_a0, done_b0, exp_da, exp_db);
      end
      if (done_a0 === 1'b1) begin order.push_back(0); $display("txn alt: done_a k=%0d", k); end
      if (done_b0 === 1'b1) begin order.push_back(1); $display("txn alt: done_b k=%0d", k); end
    end
    req_a0 = 1'b0;
    req_b0 = 1'b0;
    n_checks++;
    if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
      n_fail++;
      $display("FAIL alt_order: got %0d dones %p required A,B,A (0,1,0)", order.size(), order);
    end
    n_checks++;
    if (Q0 !== 1'b1) begin
      n_fail++;
      $display("FAIL alt_Q: got %b required 1", Q0);
    end
  endtask

  task automatic test_reset_mid_drive();
    int first_done;
    first_done = -1;
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0   = 1'b0;
    req_a0 = 1'b1; op_a0 = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (R0 !== 1'b1 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_drive_entry: got R=%b busy=%b required R=1 busy=1", R0, busy0);
    end
    rst0   = 1'b1;
    req_a0 = 1'b0;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    n_checks++;
    if ({S0, R0, busy0} !== 3'b0) begin
      n_fail++;
      $display("FAIL mid_drive_abort: got S,R,busy=%b required 000", {S0, R0, busy0});
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done_a0 !== 1'b0 || done_b0 !== 1'b0 || busy0 !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_drive_quiet k=%0d: got da=%b db=%b busy=%b required 0,0,0", k, done_a0, done_b0, busy0);
      end
    end
    // A must win contention after reset.
    req_a0 = 1'b1; op_a0 = 1'b0;
    req_b0 = 1'b1; op_b0 = 1'b1;
    for (int k = 1; k <= P0 + C0 + 1; k++) begin
      @(posedge clk);
      #1;
      if (first_done < 0 && done_a0 === 1'b1) first_done = 0;
      if (first_done < 0 && done_b0 === 1'b1) first_done = 1;
    end
    req_a0 = 1'b0;
    req_b0 = 1'b0;
    n_checks++;
    if (first_done != 0) begin
      n_fail++;
      $display("FAIL mid_drive_rr: first done owner %0d required 0 (A)", first_done);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_readback();
    bit exp_err;
`ifdef SR_READBACK_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0   = 1'b0;
    stuck0 = 1'b1;
    req_a0 = 1'b1; op_a0 = 1'b1;
    for (int k = 1; k <= P0 + C0 + 5; k++) begin
      @(posedge clk);
      #1;
      if (k == P0 + C0 + 1) begin
        req_a0 = 1'b0;
        n_checks++;
        if (done_a0 !== 1'b1 || err0 !== 1'b0) begin
          n_fail++;
          $display("FAIL readback_check_cycle: got done_a=%b err=%b required 1,0", done_a0, err0);
        end
      end
      if (k > P0 + C0 + 1) begin
        n_checks++;
        if (err0 !== exp_err) begin
          n_fail++;
          $display("FAIL readback_err k=%0d: got %b required %b", k, err0, exp_err);
        end
      end
    end
    $display("txn readback: stuck Q=0 with set op, err=%b", err0);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0   = 1'b0;
    stuck0 = 1'b0;
    n_checks++;
    if (err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL readback_clear: got err=%b required 0", err0);
    end
  endtask

  task automatic test_params();
    int r_cnt;
    bit exp_r, exp_db, exp_busy;
    r_cnt = 0;
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst1   = 1'b0;
    req_b1 = 1'b1; op_b1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      exp_r    = (k <= P1);
      exp_db   = (k == P1 + C1 + 1);
      exp_busy = (k <= P1 + C1 + 1);
      if (R1 === 1'b1) r_cnt++;
      n_checks++;
      if (R1 !== exp_r || S1 !== 1'b0) begin
        n_fail++;
        $display("FAIL params_SR k=%0d: got S=%b R=%b required S=0 R=%b", k, S1, R1, exp_r);
      end
      n_checks++;
      if (done_b1 !== exp_db || done_a1 !== 1'b0 || busy1 !== exp_busy) begin
        n_fail++;
        $display("FAIL params_done k=%0d: got db=%b da=%b busy=%b required %b,0,%b",
                 k, done_b1, done_a1, busy1, exp_db, exp_busy);
      end
      if (k == P1 + C1 + 1) begin
        req_b1 = 1'b0;
        $display("txn params: B reset op, done in cycle %0d counting the request cycle", k + 1);
      end
    end
    n_checks++;
    if (r_cnt != P1 || Q1 !== 1'b0 || err1 !== 1'b0) begin
      n_fail++;
      $display("FAIL params_summary: got R cycles=%0d Q=%b err=%b required %0d,0,0", r_cnt, Q1, err1, P1);
    end
  endtask

  // Random traffic against a timeline model: an operation occupies the
  // P0+C0+1 cycles after its grant cycle, drive first, done at the end.
  task automatic test_random();
    int  m_t;
    bit  m_owner, m_op, m_rr;
    bit  pend[2];
    bit  pop[2];
    bit  do_rst;
    bit  exp_s, exp_r, exp_da, exp_db, exp_busy;
    int  last;
    last = P0 + C0 + 1;
    rst0 = 1'b1; req_a0 = 1'b0; req_b0 = 1'b0;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    m_t = 0; m_rr = 1'b1; m_owner = 1'b0; m_op = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0; pop[0] = 1'b0; pop[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      exp_busy = (m_t != 0);
      exp_s    = (m_t >= 1) && (m_t <= P0) && m_op;
      exp_r    = (m_t >= 1) && (m_t <= P0) && !m_op;
      exp_da   = (m_t == last) && !m_owner;
      exp_db   = (m_t == last) && m_owner;
      n_checks++;
      if (S0 !== exp_s || R0 !== exp_r) begin
        n_fail++;
        $display("FAIL rand_SR c=%0d: got S=%b R=%b required S=%b R=%b", c, S0, R0, exp_s, exp_r);
      end
      n_checks++;
      if (done_a0 !== exp_da || done_b0 !== exp_db) begin
        n_fail++;
        $display("FAIL rand_done c=%0d: got a=%b b=%b required a=%b b=%b", c, done_a0, done_b0, exp_da, exp_db);
      end
      n_checks++;
      if (busy0 !== exp_busy || err0 !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_busy_err c=%0d: got busy=%b err=%b required %b,0", c, busy0, err0, exp_busy);
      end
      if (exp_da || exp_db)
        $display("txn rand c=%0d: done owner=%s op=%0d", c, m_owner ? "B" : "A", m_op);
      for (int r = 0; r < 2; r++) begin
        if (pend[r] && m_t == last && m_owner == r[0]) begin
          pend[r] = 1'b0;
        end else if (pend[r] && m_t != 0 && m_t <= P0 && m_owner == r[0] && $urandom_range(0, 7) == 0) begin
          pend[r] = 1'b0;
        end
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pop[r]  = 1'($urandom_range(0, 1));
        end else if (pend[r] && $urandom_range(0, 3) == 0) begin
          pop[r] = ~pop[r];
        end
      end
      do_rst = ($urandom_range(0, 59) == 0);
      req_a0 = pend[0]; op_a0 = pop[0];
      req_b0 = pend[1]; op_b0 = pop[1];
      rst0   = do_rst;
      if (do_rst) begin
        m_t  = 0;
        m_rr = 1'b1;
      end else if (m_t == 0) begin
        if (pend[0] || pend[1]) begin
          m_owner = (pend[0] && pend[1]) ? !m_rr : pend[1];
          m_op    = m_owner ? pop[1] : pop[0];
          m_rr    = m_owner;
          m_t     = 1;
        end
      end else if (m_t == last) begin
        m_t = 0;
      end else begin
        m_t++;
      end
      @(posedge clk);
      #1;
    end
    rst0 = 1'b0; req_a0 = 1'b0; req_b0 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; req_a0 = 1'b0; op_a0 = 1'b0; req_b0 = 1'b0; op_b0 = 1'b0;
    rst1 = 1'b1; req_a1 = 1'b0; op_a1 = 1'b0; req_b1 = 1'b0; op_b1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_set();
    test_alternate();
    test_reset_mid_drive();
    test_readback();
    test_params();
    test_random();
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
